// File: rtl/tone_synth_pkg.sv
// tone_synth_pkg: note indices, voice states and the 12 MHz half-period table
package tone_synth_pkg;
  localparam logic [5:0] NOTE_STOP = 6'd0;
  localparam logic [5:0] NOTE_C4   = 6'd1;
  localparam logic [5:0] NOTE_A4   = 6'd10;
  localparam logic [5:0] NOTE_C7   = 6'd37;
  localparam logic [5:0] NOTE_MAX  = 6'd37;
  typedef enum logic {V_IDLE, V_PLAY} voice_state_t;
  localparam logic [15:0] HALF_END [0:37] = '{
    16'd0,
    16'd22933, 16'd21645, 16'd20430, 16'd19284, 16'd18201, 16'd17180,
    16'd16215, 16'd15305, 16'd14446, 16'd13635, 16'd12870, 16'd12148,
    16'd11466, 16'd10822, 16'd10215, 16'd9641,  16'd9100,  16'd8589,
    16'd8107,  16'd7652,  16'd7223,  16'd6817,  16'd6435,  16'd6073,
    16'd5732,  16'd5411,  16'd5107,  16'd4820,  16'd4550,  16'd4294,
    16'd4053,  16'd3826,  16'd3611,  16'd3408,  16'd3217,  16'd3036,
    16'd2866
  };
  function automatic logic [15:0] half_end(input logic [5:0] n);
    return (n <= NOTE_MAX) ? HALF_END[n] : 16'd0;
  endfunction
endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice with phase counter and tick-based duration
module tone_voice import tone_synth_pkg::*; #(
  parameter int CNT_W = 18,
  parameter int DUR_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ld,
  input  logic             play,
  input  logic [CNT_W-1:0] end_val,
  input  logic [DUR_W-1:0] dur,
  input  logic             tick,
  output logic             ch_out,
  output logic             busy
);
  voice_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, end_q, end_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic out_q, out_d, wrap, expire;
  assign wrap = cnt_q == end_q;
  assign expire = tick && dur_q == DUR_W'(1);
  // a load on this channel always overrides a same-cycle tick or expiry
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    end_d = end_q;
    dur_d = dur_q;
    out_d = out_q;
    if (ld) begin
      state_d = play ? V_PLAY : V_IDLE;
      cnt_d = '0;
      end_d = end_val;
      dur_d = play ? dur : '0;
      out_d = play;
    end else if (state_q == V_PLAY) begin
      state_d = expire ? V_IDLE : V_PLAY;
      cnt_d = (wrap || expire) ? '0 : cnt_q + 1'b1;
      out_d = expire ? 1'b0 : out_q ^ wrap;
      dur_d = (tick && dur_q != '0) ? dur_q - 1'b1 : dur_q;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= V_IDLE;
      cnt_q <= '0;
      end_q <= '0;
      dur_q <= '0;
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      end_q <= end_d;
      dur_q <= dur_d;
      out_q <= out_d;
    end
  assign ch_out = out_q;
  assign busy = state_q == V_PLAY;
endmodule

// File: rtl/tone_synth.sv
// tone_synth: polyphonic square-wave synth with note handshake and PWM mix
module tone_synth import tone_synth_pkg::*; #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 18,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 12000,
  parameter int OCT_DN   = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [5:0]        cmd_note,
  input  logic [DUR_W-1:0]  cmd_dur,
  output logic [NUM_CH-1:0] ch_out,
  output logic [NUM_CH-1:0] ch_busy,
  output logic              mix_out,
  output logic              note_err
);
  localparam int PRE_W = $clog2(TICK_DIV + 1);
  logic accept, ch_ok, note_ok, tick, ld_vld, ld_play;
  logic [CH_W-1:0] ld_ch, pwm_cnt;
  logic [CNT_W-1:0] ld_end;
  logic [DUR_W-1:0] ld_dur;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0] pop;
  assign accept = cmd_valid && cmd_ready;
  assign ch_ok = int'(cmd_ch) < NUM_CH;
  assign note_ok = cmd_note != NOTE_STOP && cmd_note <= NOTE_MAX;
  assign tick = pre_cnt == PRE_W'(TICK_DIV - 1);
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + 4'(ch_out[i]);
  end
  // command stage registers the table lookup; voices load one cycle later
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      cmd_ready <= 1'b1;
      ld_vld <= 1'b0;
      ld_play <= 1'b0;
      ld_ch <= '0;
      ld_end <= '0;
      ld_dur <= '0;
      note_err <= 1'b0;
      pre_cnt <= '0;
      pwm_cnt <= '0;
      mix_out <= 1'b0;
    end else begin
      cmd_ready <= !accept;
      ld_vld <= accept && ch_ok;
      ld_play <= note_ok;
      ld_ch <= cmd_ch;
      ld_end <= CNT_W'(half_end(cmd_note)) << OCT_DN;
      ld_dur <= cmd_dur;
      note_err <= accept && (!ch_ok || (!note_ok && cmd_note != NOTE_STOP));
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= (pwm_cnt == CH_W'(NUM_CH - 1)) ? '0 : pwm_cnt + 1'b1;
      mix_out <= 4'(pwm_cnt) < pop;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_v
    tone_voice #(.CNT_W(CNT_W), .DUR_W(DUR_W)) u_voice (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .ld      (ld_vld && ld_ch == CH_W'(i)),
      .play    (ld_play),
      .end_val (ld_end),
      .dur     (ld_dur),
      .tick    (tick),
      .ch_out  (ch_out[i]),
      .busy    (ch_busy[i])
    );
  end
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: event scoreboard for two tone_synth configurations
module tb_tone_synth;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_valid = 1'b0, a_ready, a_mix, a_err;
  logic [1:0] a_ch = '0;
  logic [5:0] a_note = '0;
  logic [15:0] a_dur = '0;
  logic [3:0] a_out, a_busy;
  logic b_valid = 1'b0, b_ready, b_mix, b_err;
  logic [1:0] b_ch = '0;
  logic [5:0] b_note = '0;
  logic [15:0] b_dur = '0;
  logic [2:0] b_out, b_busy;
  tone_synth #(.NUM_CH(4), .CNT_W(18), .DUR_W(16), .TICK_DIV(100), .OCT_DN(0)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_ch(a_ch), .cmd_note(a_note), .cmd_dur(a_dur), .ch_out(a_out),
    .ch_busy(a_busy), .mix_out(a_mix), .note_err(a_err));
  tone_synth #(.NUM_CH(3), .CNT_W(18), .DUR_W(16), .TICK_DIV(100), .OCT_DN(1)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_ch(b_ch), .cmd_note(b_note), .cmd_dur(b_dur), .ch_out(b_out),
    .ch_busy(b_busy), .mix_out(b_mix), .note_err(b_err));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0, samples = 0;
  // id 0..3: dut_a voices, 4: dut_a note_err, 5..7: dut_b voices, 8: dut_b note_err
  typedef struct {int id; int lo; int hi; logic [1:0] v;} ev_t;
  ev_t q[$];
  logic [1:0] prev [9] = '{default: 2'b00};
  logic [1:0] cur [9];
  logic [3:0] ho [5] = '{default: 4'h0};
  logic hm [4] = '{default: 1'b0};
  int idx, sum;
  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
  endtask
  task automatic push(input int id, input int lo, input int hi, input logic [1:0] v);
    q.push_back('{id, lo, hi, v});
  endtask
  // voice loads at a+1 high; toggles every h cycles until the stop lands at s+1
  task automatic play_exp(input int id, input int a, input int h, input int s);
    logic o = 1'b0;
    push(id, a + 1, a + 1, 2'b11);
    for (int t = a + 1 + h; t < s + 1; t += h) begin
      push(id, t, t, {o, 1'b1});
      o = ~o;
    end
    push(id, s + 1, s + 1, 2'b00);
  endtask
  task automatic send(input bit d, input int t, input int ch, input int note, input int dur);
    while (cyc < t - 1) @(negedge clk);
    if (!d) begin
      chk("a_ready_before", int'(a_ready), 1);
      a_valid = 1'b1; a_ch = 2'(ch); a_note = 6'(note); a_dur = 16'(dur);
    end else begin
      chk("b_ready_before", int'(b_ready), 1);
      b_valid = 1'b1; b_ch = 2'(ch); b_note = 6'(note); b_dur = 16'(dur);
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk(d ? "b_ready_after_accept" : "a_ready_after_accept", int'(d ? b_ready : a_ready), 0);
  endtask
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) cur[c] = {a_out[c], a_busy[c]};
    cur[4] = {a_err, 1'b0};
    for (int c = 0; c < 3; c++) cur[5 + c] = {b_out[c], b_busy[c]};
    cur[8] = {b_err, 1'b0};
    for (int c = 0; c < 9; c++) begin
      if (cur[c] != prev[c]) begin
        idx = -1;
        foreach (q[k]) if (idx < 0 && q[k].id == c) idx = k;
        n_chk++;
        if (idx < 0)
          $display("FAIL ev%0d unexpected: got %b at cycle %0d, expected no change", c, cur[c], cyc);
        else begin
          if (cyc >= q[idx].lo && cyc <= q[idx].hi && cur[c] == q[idx].v) n_pass++;
          else $display("FAIL ev%0d: got %b at cycle %0d expected %b in cycles %0d..%0d",
                        c, cur[c], cyc, q[idx].v, q[idx].lo, q[idx].hi);
          q.delete(idx);
        end
        prev[c] = cur[c];
      end
    end
  end
  // over NUM_CH cycles of stable ch_out, mix_out must be high popcount times
  always @(negedge clk) begin
    for (int k = 4; k > 0; k--) ho[k] = ho[k-1];
    for (int k = 3; k > 0; k--) hm[k] = hm[k-1];
    ho[0] = a_out;
    hm[0] = a_mix;
    samples++;
    if (samples >= 5 && ho[1] == ho[2] && ho[2] == ho[3] && ho[3] == ho[4]) begin
      sum = int'(hm[0]) + int'(hm[1]) + int'(hm[2]) + int'(hm[3]);
      chk("mix_sum", sum, $countones(ho[1]));
    end
  end
  initial begin
    repeat (5) @(negedge clk);
    chk("rst_a_out", int'(a_out), 0);
    chk("rst_a_busy", int'(a_busy), 0);
    chk("rst_a_mix", int'(a_mix), 0);
    chk("rst_a_ready", int'(a_ready), 1);
    chk("rst_a_err", int'(a_err), 0);
    chk("rst_b_out", int'(b_out), 0);
    chk("rst_b_ready", int'(b_ready), 1);
    rst_n = 1'b1;
    play_exp(0, 10, 13636, 28000);
    send(0, 10, 0, 10, 0);
    push(1, 21, 21, 2'b11);
    push(1, 222, 321, 2'b00);
    push(1, 351, 351, 2'b11);
    push(1, 506, 605, 2'b00);
    send(0, 20, 1, 1, 3);
    play_exp(5, 30, 27271, 54900);
    send(1, 30, 0, 10, 0);
    push(8, 100, 100, 2'b10);
    push(8, 101, 101, 2'b00);
    send(1, 100, 3, 10, 0);
    send(0, 350, 1, 1, 1);
    send(0, 404, 1, 13, 2);
    push(2, 501, 501, 2'b11);
    push(2, 601, 601, 2'b00);
    push(4, 600, 600, 2'b10);
    push(4, 601, 601, 2'b00);
    send(0, 500, 2, 13, 0);
    send(0, 600, 2, 40, 0);
    send(0, 28000, 0, 0, 0);
    play_exp(0, 28100, 2867, 52000);
    play_exp(1, 28102, 5733, 52002);
    play_exp(2, 28104, 11467, 52004);
    send(0, 28100, 0, 37, 0);
    send(0, 28102, 1, 25, 0);
    send(0, 28104, 2, 13, 0);
    for (int c = 0; c < 3; c++) send(0, 52000 + 2 * c, c, 0, 0);
    for (int c = 0; c < 4; c++) play_exp(c, 52100 + 2 * c, 22934, 52300 + 2 * c);
    for (int c = 0; c < 4; c++) send(0, 52100 + 2 * c, c, 1, 0);
    for (int c = 0; c < 4; c++) send(0, 52300 + 2 * c, c, 0, 0);
    send(1, 54900, 0, 0, 0);
    push(2, 55001, 55001, 2'b11);
    push(2, 55101, 55101, 2'b00);
    send(0, 55000, 2, 13, 0);
    send(0, 55100, 3, 10, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out", int'(a_out), 0);
    chk("async_rst_busy", int'(a_busy), 0);
    chk("async_rst_ready", int'(a_ready), 1);
    chk("async_rst_mix", int'(a_mix), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("dropped_cmd_busy", int'(a_busy), 0);
    chk("pending_events", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
